// File: rtl/gpio_in_filter.sv
// Per-pin pad conditioning: 2-flop sync, programmable debounce, W1C edge flags on a mem_* register slot.
// A stable pad change captured at edge E reaches gpio_ind/irq at E+2+DBNC; bus is zero-wait, never backpressures.
module gpio_in_filter #(
   parameter int TOTAL_GPIOS = 8,
   parameter int DEBOUNCE_W  = 16
) (
   input  logic                   mem_clk,
   input  logic                   rst_n,
   input  logic [TOTAL_GPIOS-1:0] pad_in,
   input  logic                   mem_valid,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_addr,
   input  logic [3:0]             mem_wstrb,
   output logic                   mem_ready,
   output logic [31:0]            mem_rdata,
   output logic [TOTAL_GPIOS-1:0] gpio_ind,
   output logic                   irq
);

   localparam logic [3:0] ADDR_FILT    = 4'h0;
   localparam logic [3:0] ADDR_DBNC    = 4'h1;
   localparam logic [3:0] ADDR_RISE_EN = 4'h2;
   localparam logic [3:0] ADDR_FALL_EN = 4'h3;
   localparam logic [3:0] ADDR_ISF     = 4'h4;
   localparam logic [3:0] ADDR_RAW     = 4'h5;

   logic                   wr;
   logic [TOTAL_GPIOS-1:0] s1;
   logic [TOTAL_GPIOS-1:0] s2;
   logic [TOTAL_GPIOS-1:0] f;
   logic [TOTAL_GPIOS-1:0] accept;
   logic [TOTAL_GPIOS-1:0] rise_set;
   logic [TOTAL_GPIOS-1:0] fall_set;
   logic [TOTAL_GPIOS-1:0] clr;
   logic [TOTAL_GPIOS-1:0] rise_en;
   logic [TOTAL_GPIOS-1:0] fall_en;
   logic [TOTAL_GPIOS-1:0] isf;
   logic [DEBOUNCE_W-1:0]  dbnc;
   logic [DEBOUNCE_W-1:0]  cnt [TOTAL_GPIOS];
   logic                   unused_wdata;

   assign wr           = mem_valid & (&mem_wstrb);
   assign unused_wdata = &{1'b0, mem_wdata};

   // A pin flips once it has mismatched for more than DBNC cycles; >= also covers a DBNC shrunk below the count.
   always_comb begin
      accept = '0;
      for (int i = 0; i < TOTAL_GPIOS; i++) begin
         accept[i] = (s2[i] != f[i]) && (cnt[i] >= dbnc);
      end
   end

   assign rise_set = accept & s2 & rise_en;
   assign fall_set = accept & ~s2 & fall_en;
   assign clr      = (wr && mem_addr == ADDR_ISF) ? mem_wdata[TOTAL_GPIOS-1:0] : '0;

   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         s1  <= '0;
         s2  <= '0;
         f   <= '0;
         isf <= '0;
      end else begin
         s1  <= pad_in;
         s2  <= s1;
         f   <= f ^ accept;
         isf <= (isf & ~clr) | rise_set | fall_set;
      end
   end

   always_ff @(posedge mem_clk) begin
      for (int i = 0; i < TOTAL_GPIOS; i++) begin
         if (!rst_n || (s2[i] == f[i]) || accept[i]) begin
            cnt[i] <= '0;
         end else begin
            cnt[i] <= cnt[i] + DEBOUNCE_W'(1);
         end
      end
   end

   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         dbnc    <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else if (wr) begin
         case (mem_addr)
            ADDR_DBNC:    dbnc    <= mem_wdata[DEBOUNCE_W-1:0];
            ADDR_RISE_EN: rise_en <= mem_wdata[TOTAL_GPIOS-1:0];
            ADDR_FALL_EN: fall_en <= mem_wdata[TOTAL_GPIOS-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (mem_valid) begin
         case (mem_addr)
            ADDR_FILT:    mem_rdata = 32'(f);
            ADDR_DBNC:    mem_rdata = 32'(dbnc);
            ADDR_RISE_EN: mem_rdata = 32'(rise_en);
            ADDR_FALL_EN: mem_rdata = 32'(fall_en);
            ADDR_ISF:     mem_rdata = 32'(isf);
            ADDR_RAW:     mem_rdata = 32'(s2);
            default:      mem_rdata = '0;
         endcase
      end
   end

   assign mem_ready = mem_valid;
   assign gpio_ind  = f;
   assign irq       = |isf;

endmodule
